// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
//   Shared constants and types for the instruction fetch engine:
//   default reset PC, the canonical NOP encoding, the PC step and the
//   fetch FSM state type.
package ifu_fetch_pkg;

  localparam logic [63:0] IFU_DEFAULT_RESET_PC = 64'h8000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Instruction fetch engine. Drives a single-outstanding instruction
//   memory bus, buffers the returned word and presents it to the IF/ID
//   register together with its PC until pipeline control advances.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ifu_fetch_dont_fetch_i    hold the presented instruction, no PC advance
//   ifu_fetch_if_flush_i      force inst_o to NOP (combinational)
//   ifu_fetch_inst_valid_i    pipeline advances this cycle
//   ifu_fetch_redirect_i      one-cycle pulse: load redirect_pc_i
//   ifu_fetch_redirect_pc_i   redirect target (4-byte aligned)
//   ifu_fetch_req_o           bus request
//   ifu_fetch_addr_o          bus address, held until accepted
//   ifu_fetch_ready_i         bus accepts the request
//   ifu_fetch_rvalid_i        read data valid
//   ifu_fetch_rdata_i         read data
//   ifu_fetch_fetched_ok_o    inst_o / pc_o are valid
//   ifu_fetch_inst_o          instruction to IF/ID
//   ifu_fetch_pc_o            PC of inst_o
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(IFU_DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_fetch_dont_fetch_i,
  input  logic              ifu_fetch_if_flush_i,
  input  logic              ifu_fetch_inst_valid_i,
  input  logic              ifu_fetch_redirect_i,
  input  logic [ADDR_W-1:0] ifu_fetch_redirect_pc_i,
  output logic              ifu_fetch_req_o,
  output logic [ADDR_W-1:0] ifu_fetch_addr_o,
  input  logic              ifu_fetch_ready_i,
  input  logic              ifu_fetch_rvalid_i,
  input  logic [31:0]       ifu_fetch_rdata_i,
  output logic              ifu_fetch_fetched_ok_o,
  output logic [31:0]       ifu_fetch_inst_o,
  output logic [ADDR_W-1:0] ifu_fetch_pc_o
);

  ifu_state_e        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       inst_buf;
  logic              drop;
  logic              req_q;
  logic              ok_q;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_fetch_pc;

  // Wraps modulo 2^ADDR_W.
  assign pc_inc        = pc + ADDR_W'(INST_BYTES);
  // Address of the next request when leaving WAIT with discarded data.
  assign next_fetch_pc = ifu_fetch_redirect_i ? ifu_fetch_redirect_pc_i : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      inst_buf <= INST_NOP;
      drop     <= 1'b0;
      req_q    <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ifu_fetch_redirect_i) begin
            pc     <= ifu_fetch_redirect_pc_i;
            addr_q <= ifu_fetch_redirect_pc_i;
            req_q  <= 1'b1;
            state  <= ST_REQ;
          end else if (!ifu_fetch_dont_fetch_i) begin
            addr_q <= pc;
            req_q  <= 1'b1;
            state  <= ST_REQ;
          end
        end

        ST_REQ: begin
          // A request cannot be withdrawn: keep the old address on the bus
          // and mark its response for discard once it returns.
          if (ifu_fetch_redirect_i) begin
            pc   <= ifu_fetch_redirect_pc_i;
            drop <= 1'b1;
          end
          if (ifu_fetch_ready_i) begin
            req_q <= 1'b0;
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (ifu_fetch_rvalid_i) begin
            if (drop || ifu_fetch_redirect_i) begin
              // Stale response: throw it away and refetch from the new PC.
              drop   <= 1'b0;
              pc     <= next_fetch_pc;
              addr_q <= next_fetch_pc;
              req_q  <= 1'b1;
              state  <= ST_REQ;
            end else begin
              inst_buf <= ifu_fetch_rdata_i;
              ok_q     <= 1'b1;
              state    <= ST_HOLD;
            end
          end else if (ifu_fetch_redirect_i) begin
            pc   <= ifu_fetch_redirect_pc_i;
            drop <= 1'b1;
          end
        end

        ST_HOLD: begin
          // Redirect outranks the advance/hold decision.
          if (ifu_fetch_redirect_i) begin
            pc       <= ifu_fetch_redirect_pc_i;
            addr_q   <= ifu_fetch_redirect_pc_i;
            inst_buf <= INST_NOP;
            ok_q     <= 1'b0;
            req_q    <= 1'b1;
            state    <= ST_REQ;
          end else if (ifu_fetch_inst_valid_i && !ifu_fetch_dont_fetch_i) begin
            pc     <= pc_inc;
            addr_q <= pc_inc;
            ok_q   <= 1'b0;
            req_q  <= 1'b1;
            state  <= ST_REQ;
          end
        end

        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
          ok_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ifu_fetch_req_o        = req_q;
  assign ifu_fetch_addr_o       = addr_q;
  assign ifu_fetch_fetched_ok_o = ok_q;
  assign ifu_fetch_pc_o         = pc;
  assign ifu_fetch_inst_o       = ifu_fetch_if_flush_i ? INST_NOP : inst_buf;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
//   Self-checking bench for ifu_fetch: a directed cycle table, a short
//   reset-during-request sequence, and a randomized run against a
//   program-order reference model with a memory-backed bus responder.
module tb_ifu_fetch;

  localparam logic [63:0] R    = 64'h8000_0000;
  localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;
  localparam logic [31:0] D0   = 32'h00A0_0093;
  localparam logic [31:0] D1   = 32'h0010_8113;
  localparam logic [31:0] D2   = 32'h0031_0193;
  localparam logic [31:0] D3   = 32'h4020_8233;
  localparam logic [31:0] D4   = 32'h0041_A2A3;
  localparam logic [31:0] D5   = 32'h0000_0317;

  logic        clk = 1'b0;
  logic        rst;
  logic        dont_fetch, if_flush, inst_valid, redirect;
  logic [63:0] redirect_pc;
  logic        req;
  logic [63:0] addr;
  logic        ready, rvalid;
  logic [31:0] rdata;
  logic        fetched_ok;
  logic [31:0] inst;
  logic [63:0] pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.ADDR_W(64), .RESET_PC(64'h8000_0000)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ifu_fetch_dont_fetch_i  (dont_fetch),
    .ifu_fetch_if_flush_i    (if_flush),
    .ifu_fetch_inst_valid_i  (inst_valid),
    .ifu_fetch_redirect_i    (redirect),
    .ifu_fetch_redirect_pc_i (redirect_pc),
    .ifu_fetch_req_o         (req),
    .ifu_fetch_addr_o        (addr),
    .ifu_fetch_ready_i       (ready),
    .ifu_fetch_rvalid_i      (rvalid),
    .ifu_fetch_rdata_i       (rdata),
    .ifu_fetch_fetched_ok_o  (fetched_ok),
    .ifu_fetch_inst_o        (inst),
    .ifu_fetch_pc_o          (pc)
  );

  typedef struct {
    logic        rst, df, fl, iv, rd;
    logic [63:0] rpc;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_ok;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        chk_all;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rs, input logic df, input logic fl, input logic iv,
    input logic rd, input logic [63:0] rpc, input logic rdy, input logic rv,
    input logic [31:0] rdat, input logic e_req, input logic [63:0] e_addr,
    input logic e_ok, input logic [31:0] e_inst, input logic [63:0] e_pc,
    input logic chk_all);
    vec_t v;
    v.rst = rs; v.df = df; v.fl = fl; v.iv = iv; v.rd = rd; v.rpc = rpc;
    v.rdy = rdy; v.rv = rv; v.rdata = rdat; v.e_req = e_req; v.e_addr = e_addr;
    v.e_ok = e_ok; v.e_inst = e_inst; v.e_pc = e_pc; v.chk_all = chk_all;
    return v;
  endfunction

  // Contents of instruction memory as seen by the bench's bus responder.
  function automatic logic [31:0] mem(input logic [63:0] a);
    logic [31:0] x;
    x = a[31:0] ^ a[63:32];
    return (x * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_quiet();
    rst = 1'b0; dont_fetch = 1'b0; if_flush = 1'b0; inst_valid = 1'b0;
    redirect = 1'b0; redirect_pc = '0; ready = 1'b0; rvalid = 1'b0; rdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned since_ok;
    int unsigned consumed;
    int unsigned cnt;
    logic        outs;
    logic [63:0] resp_addr;
    logic [63:0] exp_pc;
    logic        prev_hold;
    logic [63:0] prev_addr;
    logic        prev_rd;
    int unsigned wait_cyc;

    drive_quiet();
    rst = 1'b1;

    // Directed table: inputs applied before an edge, outputs checked after it.
    //              rst df fl iv rd rpc        rdy rv rdata  req addr       ok inst pc         all
    tbl.push_back(mk(1, 0, 0, 0, 0, '0,        0, 0, '0,   0, R,         0, NOP, R,         1));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 0, '0,   1, R,         0, NOP, R,         0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D0,   0, '0,        1, D0,  R,         0));
    tbl.push_back(mk(0, 0, 0, 1, 0, '0,        0, 0, '0,   1, R+4,       0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D1,   0, '0,        1, D1,  R+4,       0));
    tbl.push_back(mk(0, 1, 0, 1, 0, '0,        0, 0, '0,   0, '0,        1, D1,  R+4,       0));
    tbl.push_back(mk(0, 1, 0, 1, 0, '0,        0, 0, '0,   0, '0,        1, D1,  R+4,       0));
    tbl.push_back(mk(0, 1, 0, 1, 0, '0,        0, 0, '0,   0, '0,        1, D1,  R+4,       0));
    tbl.push_back(mk(0, 0, 1, 0, 0, '0,        0, 0, '0,   0, '0,        1, NOP, R+4,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 0, '0,   0, '0,        1, D1,  R+4,       0));
    tbl.push_back(mk(0, 0, 0, 1, 0, '0,        0, 0, '0,   1, R+8,       0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 1, R+'h100,   0, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, BAD,  1, R+'h100,   0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D2,   0, '0,        1, D2,  R+'h100,   0));
    tbl.push_back(mk(0, 0, 0, 1, 0, '0,        0, 0, '0,   1, R+'h104,   0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 1, R+'h200,   0, 1, BAD,  1, R+'h200,   0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D3,   0, '0,        1, D3,  R+'h200,   0));
    tbl.push_back(mk(0, 0, 0, 1, 0, '0,        0, 0, '0,   1, R+'h204,   0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 1, R+'h300,   0, 0, '0,   1, R+'h204,   0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 0, '0,   1, R+'h204,   0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, BAD,  1, R+'h300,   0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D4,   0, '0,        1, D4,  R+'h300,   0));
    tbl.push_back(mk(0, 1, 0, 1, 1, WRAP,      0, 0, '0,   1, WRAP,      0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D5,   0, '0,        1, D5,  WRAP,      0));
    tbl.push_back(mk(0, 0, 0, 1, 0, '0,        0, 0, '0,   1, 64'h0,     0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D0,   0, '0,        1, D0,  64'h0,     0));
    tbl.push_back(mk(0, 0, 0, 1, 0, '0,        0, 0, '0,   1, 64'h4,     0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(1, 0, 0, 0, 0, '0,        0, 0, '0,   0, R,         0, NOP, R,         1));
    tbl.push_back(mk(0, 1, 0, 0, 0, '0,        0, 1, BAD,  0, R,         0, NOP, R,         1));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 0, '0,   1, R,         0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        1, 0, '0,   0, '0,        0, '0,  '0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0,        0, 1, D1,   0, '0,        1, D1,  R,         0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; dont_fetch = tbl[i].df; if_flush = tbl[i].fl;
      inst_valid = tbl[i].iv; redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
      ready = tbl[i].rdy; rvalid = tbl[i].rv; rdata = tbl[i].rdata;
      @(posedge clk); #1;
      chk("tbl_req", i, 64'(req), 64'(tbl[i].e_req));
      chk("tbl_ok",  i, 64'(fetched_ok), 64'(tbl[i].e_ok));
      if (tbl[i].e_req || tbl[i].chk_all) chk("tbl_addr", i, addr, tbl[i].e_addr);
      if (tbl[i].e_ok || tbl[i].chk_all) begin
        chk("tbl_inst", i, 64'(inst), 64'(tbl[i].e_inst));
        chk("tbl_pc",   i, pc, tbl[i].e_pc);
      end
    end

    // Reset while a request is on the bus and not yet accepted.
    drive_quiet();
    inst_valid = 1'b1;
    @(posedge clk); #1;
    chk("seq_req_pending", 0, {63'b0, req}, 64'd1);
    chk("seq_req_addr", 0, addr, R + 4);
    inst_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("seq_rst_req", 0, {63'b0, req}, 64'd0);
    chk("seq_rst_ok",  0, {63'b0, fetched_ok}, 64'd0);
    chk("seq_rst_addr", 0, addr, R);
    rst = 1'b0;
    wait_cyc = 0;
    do begin
      @(posedge clk); #1;
      wait_cyc++;
    end while (!req && wait_cyc < 10);
    chk("seq_refetch_req", 0, {63'b0, req}, 64'd1);
    chk("seq_refetch_addr", 0, addr, R);

    // Randomized run: the model tracks the PC the pipeline should see next.
    @(negedge clk);
    drive_quiet();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = R; outs = 1'b0; cnt = 0; resp_addr = '0;
    prev_hold = 1'b0; prev_addr = '0; prev_rd = 1'b0;
    since_ok = 0; consumed = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (fetched_ok) begin
        chk("rand_pc", c, pc, exp_pc);
        chk("rand_inst", c, 64'(inst), 64'(if_flush ? NOP : mem(exp_pc)));
        since_ok = 0;
      end else begin
        since_ok++;
      end
      if (prev_hold) begin
        chk("rand_req_held", c, {63'b0, req}, 64'd1);
        chk("rand_addr_held", c, addr, prev_addr);
      end
      if (req) chk("rand_single_outstanding", c, {63'b0, outs}, 64'd0);
      if (since_ok > 200) begin
        n_checks++; n_fail++;
        $display("FAIL rand_liveness[%0d]: no instruction for %0d cycles, required <= 200", c, since_ok);
        break;
      end

      // Bus responder.
      rvalid = 1'b0;
      rdata  = $urandom;
      if (outs) begin
        cnt--;
        if (cnt == 0) begin
          rvalid = 1'b1;
          rdata  = mem(resp_addr);
          outs   = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 5) begin
        rvalid = 1'b1;
        rdata  = BAD;
      end
      ready = ($urandom_range(0, 99) < 60);
      if (req && ready) begin
        outs = 1'b1;
        cnt = $urandom_range(1, 3);
        resp_addr = addr;
      end
      prev_hold = req && !ready;
      prev_addr = addr;

      // Pipeline control.
      inst_valid = ($urandom_range(0, 99) < 70);
      dont_fetch = ($urandom_range(0, 99) < 25);
      if_flush   = ($urandom_range(0, 99) < 10);
      redirect   = !prev_rd && ($urandom_range(0, 99) < 8);
      redirect_pc = (($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FF00 : R)
                    + 64'($urandom_range(0, 63) * 4);
      prev_rd = redirect;
      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (fetched_ok && inst_valid && !dont_fetch) begin
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end
    end
    chk("rand_progress", 0, 64'(consumed > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch engine. It drives the instruction-memory bus and presents one fetched instruction per pipeline advance. It is the producer of the fetched_ok handshake that pipeline control consumes. It obeys pipeline control's dont_fetch and if_flush, and accepts PC redirects from jump, branch and trap resolution.

Parameters:
RESET_PC, 64'h8000_0000, PC loaded on reset.
ADDR_W, 64, PC and bus address width.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
ifu_fetch_dont_fetch_i  in  1  from pipeline_ctrl: hold the current instruction, do not advance the PC.
ifu_fetch_if_flush_i  in  1  from pipeline_ctrl: squash the presented instruction (output NOP).
ifu_fetch_inst_valid_i  in  1  from pipeline_ctrl: the pipeline advances this cycle.
ifu_fetch_redirect_i  in  1  single-cycle pulse: load a new PC.
ifu_fetch_redirect_pc_i  in  ADDR_W  redirect target (4-byte aligned).
ifu_fetch_req_o  out  1  bus request.
ifu_fetch_addr_o  out  ADDR_W  bus address; stable while req_o=1 and ready_i=0.
ifu_fetch_ready_i  in  1  bus accepts the request.
ifu_fetch_rvalid_i  in  1  read data valid.
ifu_fetch_rdata_i  in  32  read data.
ifu_fetch_fetched_ok_o  out  1  inst_o/pc_o are valid (to pipeline_ctrl).
ifu_fetch_inst_o  out  32  instruction to the IF/ID register.
ifu_fetch_pc_o  out  ADDR_W  PC of inst_o.

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, inst buffer=NOP (32'h0000_0013), drop=0.
  - req_o=0, fetched_ok_o=0, addr_o=RESET_PC.
- At most one outstanding transaction. The response may arrive the cycle after acceptance or later.
- FSM:
  - IDLE: if !dont_fetch_i, go to REQ. Otherwise stay.
  - REQ: req_o=1, addr_o=pc. If ready_i, go to WAIT.
  - WAIT: on rvalid_i:
    - if drop=0: latch rdata into the buffer and go to HOLD.
    - if drop=1: clear drop, discard the data, go to REQ (with the redirected pc).
  - HOLD: fetched_ok_o=1; inst_o is the buffer.
    - On inst_valid_i & !dont_fetch_i: pc<=pc+4, go to REQ (back-to-back; no IDLE bubble).
    - On inst_valid_i & dont_fetch_i: stay in HOLD; buffer and pc unchanged.
- Fetch latency: 2 cycles minimum from entering REQ to fetched_ok_o, assuming ready and rvalid each respond in one cycle.
- Redirect (highest priority, any state):
  - pc <= redirect_pc_i.
  - REQ: the request stays asserted with its old address until accepted, then drop=1.
  - WAIT: drop=1.
  - HOLD or IDLE: discard the buffer, fetched_ok_o drops the next cycle, go to REQ.
- Redirect coinciding with rvalid in WAIT: the data is discarded, go to REQ.
- A redirect in HOLD overrides inst_valid_i and dont_fetch_i in the same cycle.
- if_flush_i: combinationally forces inst_o=NOP. The FSM is unaffected. A redirect is expected to follow.
- PC arithmetic is modulo 2^ADDR_W; 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Reset mid-transaction: req_o is dropped immediately. A late rvalid after reset is ignored (IDLE ignores rvalid).
- rvalid_i in any state other than WAIT is ignored.

Decomposition:
- defines.v (shared): `RESET_PC default, `INST_NOP 32'h0000_0013, state encodings `IFU_IDLE/`IFU_REQ/`IFU_WAIT/`IFU_HOLD.
- No sub-module is natural: a single FSM, a PC register and a 32-bit buffer, about 150 lines.

Test Plan:
1. Reset, bus ready with 1-cycle rvalid, inst_valid_i=1 permanently → req at 0x8000_0000, fetched_ok_o at cycle 2; pc_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 with no idle gaps.
2. HOLD with inst_valid_i=1 and dont_fetch_i=1 for 3 cycles → inst_o/pc_o unchanged, req_o=0, pc not incremented.
3. Redirect to 0x8000_0100 in WAIT, then rvalid with 0xDEAD_BEEF → 0xDEAD_BEEF never appears on inst_o; next req addr=0x8000_0100.
4. Redirect coincident with rvalid, and redirect in REQ with ready_i held low for 2 cycles → the first addr is held until accepted, its data is discarded, then a req to the target.
5. if_flush_i=1 in HOLD → inst_o=0x0000_0013 while high; buffer restored when deasserted.
6. rst asserted in WAIT, then a stray rvalid → outputs at reset values, stray data ignored, refetch from 0x8000_0000.
